binary_morph_3x3: RTL

BINARY_MORPH_3X3 -- requirements
Module: binary_morph_3x3

---
 rtl/binary_morph_3x3.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/binary_morph_3x3.sv
// binary_morph_3x3: 3x3 binary morphology (bypass / erode / dilate / gradient)
// on a streaming video input, with timing and position delayed to match the data.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_hs, i_vs, i_de         input video timing
//   i_x, i_y                 input pixel position (12 bits each)
//   i_bin                    binarised input pixel
//   morph_mode               0 bypass, 1 erode, 2 dilate, 3 gradient (latched at frame start)
//   o_hs, o_vs, o_de         timing delayed by 2 clocks
//   o_x, o_y                 position delayed by 2 clocks
//   o_bin                    morphology result (zero on the top row / left column)
//   o_data                   display pixel, o_bin replicated to 24 bits
//   o_fg_count               number of o_bin=1 pixels in the last completed frame
module binary_morph_3x3 #(
    parameter int unsigned H_ACTIVE = 1024,   // at most 4096 (12-bit i_x)
    parameter int unsigned CNT_W    = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hs,
    input  logic             i_vs,
    input  logic             i_de,
    input  logic [11:0]      i_x,
    input  logic [11:0]      i_y,
    input  logic             i_bin,
    input  logic [1:0]       morph_mode,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_de,
    output logic [11:0]      o_x,
    output logic [11:0]      o_y,
    output logic             o_bin,
    output logic [23:0]      o_data,
    output logic [CNT_W-1:0] o_fg_count
);

    localparam int unsigned AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    localparam logic [1:0] MODE_BYPASS   = 2'd0;
    localparam logic [1:0] MODE_ERODE    = 2'd1;
    localparam logic [1:0] MODE_DILATE   = 2'd2;
    localparam logic [1:0] MODE_GRADIENT = 2'd3;

    // Line buffers: lb1 holds line y-1, lb0 holds line y-2 (no reset needed)
    logic lb0 [H_ACTIVE];
    logic lb1 [H_ACTIVE];

    logic          in_range_c;
    logic [AW-1:0] addr_c;
    logic          lb0_rd_c;
    logic          lb1_rd_c;

    // Window columns, bit 2 = line y-2, bit 1 = line y-1, bit 0 = current line
    logic [2:0] c0_q, c1_q, c2_q;
    logic [2:0] c0_d, c1_d, c2_d;

    // First pipeline stage of timing and position
    logic        d1_hs_q, d1_vs_q, d1_de_q;
    logic [11:0] d1_x_q, d1_y_q;

    logic        o_hs_q, o_vs_q, o_de_q, o_bin_q;
    logic [11:0] o_x_q, o_y_q;
    logic        bin_d;

    logic             vs_q;
    logic             vs_rise_c;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
    logic [CNT_W-1:0] fg_q, fg_d;

    logic [8:0] win_c;
    logic       ero_c, dil_c, res_c;

    // Buffer addressing; out-of-range columns read as zero and are never written
    always_comb begin
        in_range_c = (32'(i_x) < H_ACTIVE);
        addr_c     = i_x[AW-1:0];
        lb0_rd_c   = 1'b0;
        lb1_rd_c   = 1'b0;
        if (in_range_c) begin
            lb0_rd_c = lb0[addr_c];
            lb1_rd_c = lb1[addr_c];
        end
    end

    // Line buffer update: read-before-write shifts line y-1 down to y-2
    always_ff @(posedge clk) begin
        if (i_de && in_range_c) begin
            lb1[addr_c] <= i_bin;
            lb0[addr_c] <= lb1_rd_c;
        end
    end

    // Next-state logic: window shift, result, mode latch, frame counter
    always_comb begin
        c0_d = c0_q;
        c1_d = c1_q;
        c2_d = c2_q;
        if (i_de) begin
            c0_d = c1_q;
            c1_d = c2_q;
            c2_d = {lb0_rd_c, lb1_rd_c, i_bin};
        end

        win_c = {c0_q, c1_q, c2_q};
        ero_c = &win_c;
        dil_c = |win_c;
        case (mode_q)
            MODE_BYPASS:   res_c = c1_q[1];
            MODE_ERODE:    res_c = ero_c;
            MODE_DILATE:   res_c = dil_c;
            MODE_GRADIENT: res_c = dil_c & ~ero_c;
            default:       res_c = c1_q[1];
        endcase

        // The window centre is one pixel up and left, so column 0 / row 0 have no source
        bin_d = d1_de_q && (d1_x_q != 12'd0) && (d1_y_q != 12'd0) && res_c;

        vs_rise_c = i_vs && !vs_q;
        mode_d    = vs_rise_c ? morph_mode : mode_q;

        cnt_inc_c = (o_de_q && o_bin_q && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        if (vs_rise_c) begin
            fg_d  = cnt_inc_c;
            cnt_d = '0;
        end else begin
            fg_d  = fg_q;
            cnt_d = cnt_inc_c;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            c0_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            d1_hs_q <= 1'b0;
            d1_vs_q <= 1'b0;
            d1_de_q <= 1'b0;
            d1_x_q  <= '0;
            d1_y_q  <= '0;
            o_hs_q  <= 1'b0;
            o_vs_q  <= 1'b0;
            o_de_q  <= 1'b0;
            o_x_q   <= '0;
            o_y_q   <= '0;
            o_bin_q <= 1'b0;
            vs_q    <= 1'b0;
            mode_q  <= MODE_BYPASS;
            cnt_q   <= '0;
            fg_q    <= '0;
        end else begin
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            d1_hs_q <= i_hs;
            d1_vs_q <= i_vs;
            d1_de_q <= i_de;
            d1_x_q  <= i_x;
            d1_y_q  <= i_y;
            o_hs_q  <= d1_hs_q;
            o_vs_q  <= d1_vs_q;
            o_de_q  <= d1_de_q;
            o_x_q   <= d1_x_q;
            o_y_q   <= d1_y_q;
            o_bin_q <= bin_d;
            vs_q    <= i_vs;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            fg_q    <= fg_d;
        end
    end

    assign o_hs       = o_hs_q;
    assign o_vs       = o_vs_q;
    assign o_de       = o_de_q;
    assign o_x        = o_x_q;
    assign o_y        = o_y_q;
    assign o_bin      = o_bin_q;
    assign o_data     = {24{o_bin_q}};
    assign o_fg_count = fg_q;

endmodule
